// File: rtl/dmem_responder.sv
// Data-memory responder: word SRAM with byte strobes behind a valid/ready request port.
// Latency LATENCY cycles from request to mem_ready; one request in flight, mem_valid ignored while BUSY.
module dmem_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata
);

  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam logic [63:0] SPAN  = 64'd4 << DEPTH_LOG2;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        instr_q, instr_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH];

  logic                  accept, complete, in_range, do_write;
  logic [31:0]           req_addr, req_wdata, offset;
  logic [3:0]            req_wstrb;
  logic [DEPTH_LOG2-1:0] idx;

  assign accept = (state_q == IDLE) && mem_valid;

  // With LATENCY=1 the accept edge is also the completion edge, so the live inputs are used directly.
  always_comb begin
    req_addr  = addr_q;
    req_wdata = wdata_q;
    req_wstrb = instr_q ? 4'b0 : wstrb_q;
    if (state_q == IDLE) begin
      req_addr  = mem_addr;
      req_wdata = mem_wdata;
      req_wstrb = mem_instr ? 4'b0 : mem_wstrb;
    end
  end

  always_comb begin
    offset   = req_addr - BASE_ADDR;
    in_range = (req_addr >= BASE_ADDR) && ({32'b0, offset} < SPAN);
    idx      = offset[DEPTH_LOG2+1:2];
    // A held-low reset must never let a write slip into the unreset array.
    complete = rst && ((accept && (LATENCY == 1)) ||
                       ((state_q == BUSY) && (cnt_q == 4'd1)));
    do_write = complete && in_range && (req_wstrb != 4'b0);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (LATENCY > 1)) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    instr_d = instr_q;
    if (accept) begin
      cnt_d   = LAT_M1;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      wstrb_d = mem_wstrb;
      instr_d = mem_instr;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - 4'd1;
    end
    ready_d = complete;
    rdata_d = 32'b0;
    if (complete && in_range && (req_wstrb == 4'b0)) rdata_d = mem[idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 4'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      wstrb_q <= 4'b0;
      instr_q <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      instr_q <= instr_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;

endmodule
